// File: rtl/apb_uart_fifo_link.sv
// APB-attached UART: programmable 16x baud divisor, runtime parity, RX FIFO,
// internal loopback (RX fed from TX) and sticky error flags driven out as pins.
module apb_uart_fifo_link #(
    parameter int          DATA_BITS     = 8,
    parameter int          RX_FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RESET    = 16'd1
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [4:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    input  logic       RX,
    output logic       TX,
    output logic       TXRDY,
    output logic       RXRDY,
    output logic       PARITY_ERR,
    output logic       FRAMING_ERR,
    output logic       OVERFLOW
);

    localparam int          PW       = $clog2(RX_FIFO_DEPTH);
    localparam int          CW       = PW + 1;
    localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

    localparam logic [2:0]  R_TXDATA = 3'd0, R_RXDATA = 3'd1, R_BAUD_LO = 3'd2,
                            R_BAUD_HI = 3'd3, R_CTRL = 3'd4, R_STATUS = 3'd5;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_e;

    tx_state_e              tx_state_q, tx_state_d;
    rx_state_e              rx_state_q, rx_state_d;
    logic [15:0]            baud_q, baud_d, baud_cnt_q, baud_cnt_d;
    logic [2:0]             ctrl_q, ctrl_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d, tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic                   hold_full_q, hold_full_d, tx_q, tx_d;
    logic                   tx_par_en_q, tx_par_en_d, tx_odd_q, tx_odd_d;
    logic                   rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d;
    logic [3:0]             tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]             tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic                   rx_s1_q, rx_s2_q, rx_prev_q;
    logic [DATA_BITS-1:0]   mem_q [RX_FIFO_DEPTH];
    logic [DATA_BITS-1:0]   mem_d [RX_FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   pe_q, pe_d, fe_q, fe_d, ovf_q, ovf_d;

    logic                   wr_en, rd_en, baud_wr, tick, rx_line, stat_rd;
    logic                   rx_push, pe_set, fe_set, pop, push_ok, full;
    logic [2:0]             reg_idx;
    logic [DATA_BITS-1:0]   fifo_head;
    logic                   unused_addr;

    assign reg_idx     = PADDR[4:2];
    assign unused_addr = ^PADDR[1:0];
    assign wr_en       = PSEL & PENABLE & PWRITE;
    assign rd_en       = PSEL & PENABLE & ~PWRITE;
    assign baud_wr     = wr_en && (reg_idx == R_BAUD_LO || reg_idx == R_BAUD_HI);
    assign stat_rd     = rd_en && reg_idx == R_STATUS;
    assign tick        = (baud_cnt_q == baud_q);
    assign rx_line     = ctrl_q[2] ? tx_q : rx_s2_q;
    assign full        = (count_q == CW'(RX_FIFO_DEPTH));
    assign fifo_head   = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign TX          = tx_q;
    assign TXRDY       = ~hold_full_q;
    assign RXRDY       = (count_q != '0);
    assign PARITY_ERR  = pe_q;
    assign FRAMING_ERR = fe_q;
    assign OVERFLOW    = ovf_q;

    // Read mux, combinational from the register index
    always_comb begin
        PRDATA = '0;
        case (reg_idx)
            R_RXDATA:  PRDATA = 8'(fifo_head);
            R_BAUD_LO: PRDATA = baud_q[7:0];
            R_BAUD_HI: PRDATA = baud_q[15:8];
            R_CTRL:    PRDATA = {5'b0, ctrl_q};
            R_STATUS:  PRDATA = {3'b0, fe_q, ovf_q, pe_q, RXRDY, TXRDY};
            default:   PRDATA = '0;
        endcase
    end

    // Register writes, baud counter and holding-register load
    always_comb begin
        baud_d      = baud_q;
        ctrl_d      = ctrl_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (wr_en && reg_idx == R_BAUD_LO) baud_d[7:0]  = PWDATA;
        if (wr_en && reg_idx == R_BAUD_HI) baud_d[15:8] = PWDATA;
        if (wr_en && reg_idx == R_CTRL)    ctrl_d       = PWDATA[2:0];
        if (wr_en && reg_idx == R_TXDATA && !hold_full_q) begin
            hold_d      = PWDATA[DATA_BITS-1:0];
            hold_full_d = 1'b1;
        end
        if (tx_state_q == TX_IDLE && tick && hold_full_q) hold_full_d = 1'b0;
        baud_cnt_d = (baud_wr || tick) ? '0 : baud_cnt_q + 16'd1;
    end

    // TX sequencer; the line level is registered alongside each state change
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_idx_d    = tx_idx_q;
        tx_shift_d  = tx_shift_q;
        tx_par_en_d = tx_par_en_q;
        tx_odd_d    = tx_odd_q;
        tx_d        = tx_q;
        if (tx_state_q == TX_IDLE) begin
            if (tick && hold_full_q) begin
                tx_state_d  = TX_START;
                tx_shift_d  = hold_q;
                tx_par_en_d = ctrl_q[0];
                tx_odd_d    = ctrl_q[1];
                tx_cnt_d    = '0;
                tx_d        = 1'b0;
            end
        end else if (tick) begin
            tx_cnt_d = tx_cnt_q + 4'd1;
            if (tx_cnt_q == 4'd15) begin
                tx_cnt_d = '0;
                case (tx_state_q)
                    TX_START: begin
                        tx_state_d = TX_DATA;
                        tx_idx_d   = '0;
                        tx_d       = tx_shift_q[0];
                    end
                    TX_DATA: begin
                        if (tx_idx_q != LAST_IDX) begin
                            tx_idx_d = tx_idx_q + 3'd1;
                            tx_d     = tx_shift_q[tx_idx_q + 3'd1];
                        end else if (tx_par_en_q) begin
                            tx_state_d = TX_PARITY;
                            tx_d       = (^tx_shift_q) ^ tx_odd_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_d       = 1'b1;
                        end
                    end
                    TX_PARITY: begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end
                    default: begin
                        tx_state_d = TX_IDLE;
                        tx_d       = 1'b1;
                    end
                endcase
            end
        end
    end

    // RX sequencer, sampling each bit at tick 8 of its window
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_idx_d    = rx_idx_q;
        rx_shift_d  = rx_shift_q;
        rx_par_en_d = rx_par_en_q;
        rx_odd_d    = rx_odd_q;
        rx_push     = 1'b0;
        pe_set      = 1'b0;
        fe_set      = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_line) begin
                rx_state_d  = RX_START;
                rx_cnt_d    = '0;
                rx_par_en_d = ctrl_q[0];
                rx_odd_d    = ctrl_q[1];
            end
            RX_WAIT: if (rx_line) rx_state_d = RX_IDLE;
            default: if (tick) begin
                rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == 4'd7) begin
                    case (rx_state_q)
                        RX_START:  if (rx_line) rx_state_d = RX_IDLE;
                        RX_DATA:   rx_shift_d = {rx_line, rx_shift_q[DATA_BITS-1:1]};
                        RX_PARITY: pe_set = (rx_line != ((^rx_shift_q) ^ rx_odd_q));
                        default: begin
                            rx_push    = rx_line;
                            fe_set     = ~rx_line;
                            rx_state_d = rx_line ? RX_IDLE : RX_WAIT;
                        end
                    endcase
                end else if (rx_cnt_q == 4'd15) begin
                    rx_cnt_d = '0;
                    case (rx_state_q)
                        RX_START: begin
                            rx_state_d = RX_DATA;
                            rx_idx_d   = '0;
                        end
                        RX_DATA: begin
                            if (rx_idx_q != LAST_IDX) rx_idx_d = rx_idx_q + 3'd1;
                            else rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
                        end
                        default: rx_state_d = RX_STOP;
                    endcase
                end
            end
        endcase
    end

    // RX FIFO and sticky flags; a full FIFO still accepts a push when popped that cycle
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop      = rd_en && reg_idx == R_RXDATA && count_q != '0;
        push_ok  = rx_push && (!full || pop);
        if (push_ok) begin
            mem_d[wr_ptr_q] = rx_shift_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q;
        if (push_ok && !pop) count_d = count_q + CW'(1);
        if (!push_ok && pop) count_d = count_q - CW'(1);
        pe_d  = (pe_q  & ~stat_rd) | pe_set;
        fe_d  = (fe_q  & ~stat_rd) | fe_set;
        ovf_d = (ovf_q & ~stat_rd) | (rx_push && full && !pop);
    end

    // State registers
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            tx_state_q <= TX_IDLE;      rx_state_q <= RX_IDLE;
            baud_q <= BAUD_RESET;       baud_cnt_q <= '0;
            ctrl_q <= '0;               hold_q <= '0;
            hold_full_q <= 1'b0;        tx_q <= 1'b1;
            tx_shift_q <= '0;           rx_shift_q <= '0;
            tx_par_en_q <= 1'b0;        tx_odd_q <= 1'b0;
            rx_par_en_q <= 1'b0;        rx_odd_q <= 1'b0;
            tx_cnt_q <= '0;             rx_cnt_q <= '0;
            tx_idx_q <= '0;             rx_idx_q <= '0;
            rx_s1_q <= 1'b1;            rx_s2_q <= 1'b1;
            rx_prev_q <= 1'b1;          mem_q <= '{default: '0};
            wr_ptr_q <= '0;             rd_ptr_q <= '0;
            count_q <= '0;              pe_q <= 1'b0;
            fe_q <= 1'b0;               ovf_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;   rx_state_q <= rx_state_d;
            baud_q <= baud_d;           baud_cnt_q <= baud_cnt_d;
            ctrl_q <= ctrl_d;           hold_q <= hold_d;
            hold_full_q <= hold_full_d; tx_q <= tx_d;
            tx_shift_q <= tx_shift_d;   rx_shift_q <= rx_shift_d;
            tx_par_en_q <= tx_par_en_d; tx_odd_q <= tx_odd_d;
            rx_par_en_q <= rx_par_en_d; rx_odd_q <= rx_odd_d;
            tx_cnt_q <= tx_cnt_d;       rx_cnt_q <= rx_cnt_d;
            tx_idx_q <= tx_idx_d;       rx_idx_q <= rx_idx_d;
            rx_s1_q <= RX;              rx_s2_q <= rx_s1_q;
            rx_prev_q <= rx_line;       mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d;       rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;         pe_q <= pe_d;
            fe_q <= fe_d;               ovf_q <= ovf_d;
        end
    end

endmodule
